// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_stream_ctrl (with companion package aes_pkg)
// Description : Request/response initiator for a one-shot AES core. It takes
//               a key/mode config, then a valid/ready stream of 128-bit
//               blocks. For each block it issues a single core request and
//               returns the result on a valid/ready output stream.
//               Supported modes are ECB encrypt, ECB decrypt and CTR
//               (keystream XOR).
//
// Ports       : clock      - rising-edge clock
//               reset      - asynchronous, active-low reset
//               cfg_*      - config handshake (key, mode, CTR initial counter)
//               in_*       - input block stream (valid/ready, data, last)
//               out_*      - output block stream (valid/ready, data, last)
//               busy       - high whenever a message is in progress
//               aes_in     - request to the core (enable pulse, func, data)
//               aes_out    - response from the core (ready pulse, data)
//
// Revision    : 1.0 - initial release
// ============================================================================

package aes_pkg;

    // Request to the AES core. enable is a one-cycle strobe; func and data
    // are held stable until the core answers.
    typedef struct packed {
        logic         enable;
        logic [1:0]   func;
        logic [255:0] data;
    } aes_in_type;

    // Response from the AES core. ready is a one-cycle strobe; only the low
    // 128 bits of data carry a block result.
    typedef struct packed {
        logic         ready;
        logic [255:0] data;
    } aes_out_type;

endpackage

module aes_stream_ctrl #(
    parameter logic [1:0] FUNC_KEY = 2'd0,
    parameter logic [1:0] FUNC_ENC = 2'd1,
    parameter logic [1:0] FUNC_DEC = 2'd2
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [255:0]         cfg_key,
    input  logic [1:0]           cfg_mode,
    input  logic [127:0]         cfg_iv,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 in_last,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 out_last,

    output logic                 busy,

    output aes_pkg::aes_in_type  aes_in,
    input  aes_pkg::aes_out_type aes_out
);

    // Internal mode encoding. Config mode 3 is folded into ECB encrypt when
    // latched, so only these three values ever appear in r_mode.
    localparam logic [1:0] c_MODE_ECB_ENC = 2'd0;
    localparam logic [1:0] c_MODE_ECB_DEC = 2'd1;
    localparam logic [1:0] c_MODE_CTR     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_REQ  = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_WAIT_IN  = 3'd3,
        ST_BLK_REQ  = 3'd4,
        ST_BLK_WAIT = 3'd5,
        ST_OUT      = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [1:0]     r_mode;
    logic [127:0]   r_ctr;
    logic [127:0]   r_blk;        // latched input block (XOR operand in CTR)
    logic           r_last;
    logic [1:0]     r_func;       // request func presented to the core
    logic [255:0]   r_data;       // request data presented to the core
    logic           r_out_valid;
    logic [127:0]   r_out_data;
    logic           r_out_last;

    logic           w_cfg_fire;
    logic           w_in_fire;
    logic           w_blk_done;
    logic           w_out_fire;
    logic           w_req;
    logic           w_is_ctr;
    logic [127:0]   w_resp;
    logic           w_unused_resp_hi;

    // ------------------------------------------------------------------
    // Handshake decode. Core ready is only honoured in the wait states;
    // a stray strobe anywhere else has no effect.
    // ------------------------------------------------------------------
    assign w_cfg_fire = (r_state == ST_IDLE)     && cfg_valid;
    assign w_in_fire  = (r_state == ST_WAIT_IN)  && in_valid;
    assign w_blk_done = (r_state == ST_BLK_WAIT) && aes_out.ready;
    assign w_out_fire = (r_state == ST_OUT)      && out_ready;
    assign w_req      = (r_state == ST_KEY_REQ)  || (r_state == ST_BLK_REQ);
    assign w_is_ctr   = (r_mode == c_MODE_CTR);
    assign w_resp     = aes_out.data[127:0];

    // The upper response half only matters for key expansion, which this
    // block never reads back.
    assign w_unused_resp_hi = ^aes_out.data[255:128];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Request states last exactly one cycle, which is
    // what makes the enable strobe a single-cycle pulse.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_state_nxt = ST_KEY_REQ;
                end
            end
            ST_KEY_REQ: begin
                w_state_nxt = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                if (aes_out.ready) begin
                    w_state_nxt = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    w_state_nxt = ST_BLK_REQ;
                end
            end
            ST_BLK_REQ: begin
                w_state_nxt = ST_BLK_WAIT;
            end
            ST_BLK_WAIT: begin
                if (aes_out.ready) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = r_out_last ? ST_IDLE : ST_WAIT_IN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config latch and core request registers. func/data are loaded on the
    // accepting handshake so they are already valid in the request cycle
    // and simply stay put until the next load.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode <= c_MODE_ECB_ENC;
            r_ctr  <= '0;
            r_blk  <= '0;
            r_last <= 1'b0;
            r_func <= '0;
            r_data <= '0;
        end else begin
            if (w_cfg_fire) begin
                r_mode <= (cfg_mode == 2'd3) ? c_MODE_ECB_ENC : cfg_mode;
                r_ctr  <= cfg_iv;
                r_func <= FUNC_KEY;
                r_data <= cfg_key;
            end

            if (w_in_fire) begin
                r_blk  <= in_data;
                r_last <= in_last;
                r_func <= (r_mode == c_MODE_ECB_DEC) ? FUNC_DEC : FUNC_ENC;
                r_data <= {128'b0, (w_is_ctr ? r_ctr : in_data)};
            end

            // Counter advances once the keystream for the current value is
            // consumed; natural 128-bit overflow wraps all-ones to zero.
            if (w_blk_done && w_is_ctr) begin
                r_ctr <= r_ctr + 128'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stream registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_blk_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_is_ctr ? (w_resp ^ r_blk) : w_resp;
                r_out_last  <= r_last;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign cfg_ready = (r_state == ST_IDLE);
    assign in_ready  = (r_state == ST_WAIT_IN);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    always_comb begin
        aes_in        = '0;
        aes_in.enable = w_req;
        aes_in.func   = r_func;
        aes_in.data   = r_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_stream_ctrl
// Description : Directed self-checking bench for aes_stream_ctrl. The bench
//               plays the AES core (known-answer vectors plus a simple
//               deterministic mapping) and keeps a queue of expected output
//               blocks filled when each block is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_stream_ctrl;

    localparam logic [1:0] c_FUNC_KEY = 2'd0;
    localparam logic [1:0] c_FUNC_ENC = 2'd1;
    localparam logic [1:0] c_FUNC_DEC = 2'd2;

    localparam logic [255:0] c_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic                 clock;
    logic                 reset;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [255:0]         cfg_key;
    logic [1:0]           cfg_mode;
    logic [127:0]         cfg_iv;
    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [127:0]         out_data;
    logic                 out_last;
    logic                 busy;
    aes_pkg::aes_in_type  aes_in;
    aes_pkg::aes_out_type aes_out;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    logic [127:0] exp_q[$];
    logic         exp_last_q[$];

    aes_stream_ctrl #(
        .FUNC_KEY (c_FUNC_KEY),
        .FUNC_ENC (c_FUNC_ENC),
        .FUNC_DEC (c_FUNC_DEC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_key   (cfg_key),
        .cfg_mode  (cfg_mode),
        .cfg_iv    (cfg_iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .aes_in    (aes_in),
        .aes_out   (aes_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts every cycle the core sees enable high.
    always @(posedge clock) begin
        if (aes_in.enable === 1'b1) en_cnt = en_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the core: known-answer AES-256 pair, otherwise a fixed
    // reversible scramble so wrong inputs give visibly wrong outputs.
    function automatic logic [127:0] core_fn(input logic [1:0] func, input logic [127:0] x);
        if (func == c_FUNC_ENC && x == c_PT) return c_CT;
        if (func == c_FUNC_DEC && x == c_CT) return c_PT;
        return {x[63:0], x[127:64]} ^ 128'h0123456789abcdeffedcba9876543210
               ^ ((func == c_FUNC_DEC) ? {128{1'b1}} : 128'h0);
    endfunction

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait some cycles, then answer the request currently on aes_in.
    task automatic core_respond(input int dly);
        repeat (dly) tick();
        aes_out.ready = 1'b1;
        aes_out.data  = {rnd128(), core_fn(aes_in.func, aes_in.data[127:0])};
        tick();
        aes_out.ready = 1'b0;
        aes_out.data  = {rnd128(), rnd128()};
    endtask

    task automatic do_cfg(input logic [255:0] key, input logic [1:0] mode, input logic [127:0] iv);
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_key   = key;
        cfg_mode  = mode;
        cfg_iv    = iv;
        tick();
        cfg_valid = 1'b0;
        cfg_key   = {rnd128(), rnd128()};
        chk("key_req_enable", aes_in.enable, 1);
        chk("key_req_func", aes_in.func, c_FUNC_KEY);
        chk("key_req_data", aes_in.data, key);
        chk("key_req_busy", busy, 1);
        tick();
        chk("key_enable_pulse", aes_in.enable, 0);
        chk("key_data_hold", aes_in.data, key);
        core_respond(3);
        chk("wait_in_ready", in_ready, 1);
    endtask

    task automatic send_block(input logic [127:0] data, input logic last,
                              input logic [127:0] exp_x, input logic [1:0] exp_func,
                              input logic [127:0] exp_out, input int hold);
        logic [127:0] got;
        int           en0;
        exp_q.push_back(exp_out);
        exp_last_q.push_back(last);
        chk("blk_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
        in_last  = 1'b0;
        chk("blk_req_enable", aes_in.enable, 1);
        chk("blk_req_func", aes_in.func, exp_func);
        chk("blk_req_data", aes_in.data, {128'b0, exp_x});
        chk("blk_in_ready_low", in_ready, 0);
        tick();
        chk("blk_enable_pulse", aes_in.enable, 0);
        core_respond(2);
        chk("out_valid_latency", out_valid, 1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            chk("out_data", out_data, got);
            chk("out_last", out_last, exp_last_q.pop_front());
        end
        got = out_data;
        en0 = en_cnt;
        repeat (hold) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, got);
            chk("hold_in_ready", in_ready, 0);
        end
        chk("no_extra_enable", en_cnt, en0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_clear", out_valid, 0);
        if (last) begin
            chk("back_to_idle", cfg_ready, 1);
            chk("idle_not_busy", busy, 0);
        end else begin
            chk("next_wait_in", in_ready, 1);
        end
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] d3;
        int           en0;

        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_key   = '0;
        cfg_mode  = '0;
        cfg_iv    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        aes_out   = '0;

        repeat (3) tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aes_in", aes_in, 0);
        reset = 1'b1;
        tick();

        // ECB encrypt known answer, single last block
        do_cfg(c_KEY, 2'd0, rnd128());
        send_block(c_PT, 1'b1, c_PT, c_FUNC_ENC, c_CT, 0);

        // ECB decrypt known answer, output held off for 10 cycles
        do_cfg(c_KEY, 2'd1, rnd128());
        send_block(c_CT, 1'b1, c_CT, c_FUNC_DEC, c_PT, 10);

        // CTR with counter wrap; stray core ready while waiting for input
        do_cfg(c_KEY, 2'd2, {128{1'b1}});
        en0 = en_cnt;
        aes_out.ready = 1'b1;
        aes_out.data  = {rnd128(), rnd128()};
        tick();
        aes_out.ready = 1'b0;
        tick();
        chk("stray_ready_in_ready", in_ready, 1);
        chk("stray_ready_out_valid", out_valid, 0);
        chk("stray_ready_busy", busy, 1);
        chk("stray_ready_no_enable", en_cnt, en0);
        d1 = rnd128();
        d2 = rnd128();
        send_block(d1, 1'b0, {128{1'b1}}, c_FUNC_ENC,
                   core_fn(c_FUNC_ENC, {128{1'b1}}) ^ d1, 2);
        send_block(d2, 1'b1, 128'h0, c_FUNC_ENC,
                   core_fn(c_FUNC_ENC, 128'h0) ^ d2, 0);

        // Mode 3 behaves as ECB encrypt
        do_cfg(c_KEY, 2'd3, rnd128());
        d3 = rnd128();
        send_block(d3, 1'b1, d3, c_FUNC_ENC, core_fn(c_FUNC_ENC, d3), 1);

        // Reset while a block is in flight
        do_cfg(c_KEY, 2'd0, rnd128());
        in_valid = 1'b1;
        in_data  = rnd128();
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_aes_in", aes_in, 0);
        tick();
        reset = 1'b1;
        en0 = en_cnt;
        aes_out.ready = 1'b1;
        aes_out.data  = {rnd128(), rnd128()};
        tick();
        aes_out.ready = 1'b0;
        repeat (3) tick();
        chk("late_ready_no_enable", en_cnt, en0);
        chk("late_ready_out_valid", out_valid, 0);
        chk("late_ready_idle", cfg_ready, 1);
        chk("late_ready_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
